// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: bars, checker, gradient and a bouncing box.
// Two-stage pipeline; mode, frame count and box move only at frame start.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX      = 32,
  parameter int STEP     = 2
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [1:0]  iMode,
  input  logic        iBlank_n,
  input  logic        iHS,
  input  logic        iVS,
  input  logic [10:0] iX,
  input  logic [10:0] iY,
  output logic [3:0]  oR,
  output logic [3:0]  oG,
  output logic [3:0]  oB,
  output logic        oHS,
  output logic        oVS,
  output logic        oBlank_n,
  output logic [7:0]  oFrame_cnt
);

  localparam int         BAR_W  = H_ACTIVE / 8;
  localparam logic [9:0] BX_MAX = 10'(H_ACTIVE - BOX);
  localparam logic [9:0] BY_MAX = 10'(V_ACTIVE - BOX);

  logic        s1_blank;
  logic        s1_hs;
  logic        s1_vs;
  logic [10:0] s1_x;
  logic [10:0] s1_y;
  logic        vs_prev;
  logic        live;
  logic [1:0]  mode;
  logic [9:0]  bx;
  logic [9:0]  by;
  logic        dx;
  logic        dy;

  logic        frame_start;
  logic [10:0] bar_q;
  logic [2:0]  idx;
  logic        in_box;
  logic [11:0] rgb;
  logic [10:0] nx;
  logic [10:0] ny;

  // Result is {new_dir, new_pos}.
  function automatic logic [10:0] bounce(
    input logic [9:0] pos,
    input logic       dir,
    input logic [9:0] lim
  );
    logic [10:0] r;
    if (!dir) begin
      if ({1'b0, pos} + 11'(STEP) > {1'b0, lim})
        r = {1'b1, lim};
      else
        r = {1'b0, pos + 10'(STEP)};
    end else begin
      if (pos < 10'(STEP))
        r = {1'b0, 10'd0};
      else
        r = {1'b1, pos - 10'(STEP)};
    end
    return r;
  endfunction

  assign frame_start = vs_prev & ~s1_vs;
  assign nx = bounce(bx, dx, BX_MAX);
  assign ny = bounce(by, dy, BY_MAX);

  always_comb begin
    bar_q  = s1_x / 11'(BAR_W);
    idx    = (bar_q > 11'd7) ? 3'd7 : bar_q[2:0];
    in_box = (s1_x >= {1'b0, bx}) &&
             (s1_x < {1'b0, bx} + 11'(BOX)) &&
             (s1_y >= {1'b0, by}) &&
             (s1_y < {1'b0, by} + 11'(BOX));
    rgb = 12'h000;
    unique case (mode)
      2'd0: rgb = {{4{~idx[1]}}, {4{~idx[2]}}, {4{~idx[0]}}};
      2'd1: rgb = {12{s1_x[5] ^ s1_y[5]}};
      2'd2: rgb = {s1_x[9:6], s1_y[8:5], oFrame_cnt[7:4]};
      2'd3: rgb = in_box ? 12'hFFF : 12'h004;
    endcase
    if (!s1_blank)
      rgb = 12'h000;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      s1_blank   <= 1'b0;
      s1_hs      <= 1'b1;
      s1_vs      <= 1'b1;
      s1_x       <= '0;
      s1_y       <= '0;
      vs_prev    <= 1'b0;
      live       <= 1'b0;
      mode       <= 2'd0;
      bx         <= '0;
      by         <= '0;
      dx         <= 1'b0;
      dy         <= 1'b0;
      oFrame_cnt <= '0;
      oR         <= '0;
      oG         <= '0;
      oB         <= '0;
      oHS        <= 1'b1;
      oVS        <= 1'b1;
      oBlank_n   <= 1'b0;
    end else begin
      s1_blank <= iBlank_n;
      s1_hs    <= iHS;
      s1_vs    <= iVS;
      s1_x     <= iX;
      s1_y     <= iY;
      // vs_prev only carries real samples, never the reset value
      live     <= 1'b1;
      vs_prev  <= s1_vs & live;
      if (frame_start) begin
        mode       <= iMode;
        oFrame_cnt <= oFrame_cnt + 8'd1;
        bx         <= nx[9:0];
        dx         <= nx[10];
        by         <= ny[9:0];
        dy         <= ny[10];
      end
      {oR, oG, oB} <= rgb;
      oHS          <= s1_hs;
      oVS          <= s1_vs;
      oBlank_n     <= s1_blank;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised scoreboard bench for vga_pattern_gen against a
// frame-level reference model.
module tb_vga_pattern_gen;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  iMode = 2'd0;
  logic        iBlank_n = 1'b0;
  logic        iHS = 1'b1;
  logic        iVS = 1'b1;
  logic [10:0] iX = '0;
  logic [10:0] iY = '0;
  logic [3:0]  oR, oG, oB;
  logic        oHS, oVS, oBlank_n;
  logic [7:0]  oFrame_cnt;

  vga_pattern_gen dut (
    .vga_clk(vga_clk), .reset(reset), .iMode(iMode),
    .iBlank_n(iBlank_n), .iHS(iHS), .iVS(iVS),
    .iX(iX), .iY(iY), .oR(oR), .oG(oG), .oB(oB),
    .oHS(oHS), .oVS(oVS), .oBlank_n(oBlank_n),
    .oFrame_cnt(oFrame_cnt)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;
  bit running = 0;

  // Reference state, counted in frames since reset
  int m_mode, m_cnt, frames, nsamp;
  bit pv1, pv2;
  int bxs[1024];
  int bys[1024];
  logic [11:0] bars[8];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic void fill_axis(int lim, output int t[1024]);
    int pos = 0;
    bit down = 0;
    t[0] = 0;
    for (int n = 1; n < 1024; n++) begin
      if (!down) begin
        if (pos + 2 > lim) begin pos = lim; down = 1; end
        else pos += 2;
      end else begin
        if (pos < 2) begin pos = 0; down = 0; end
        else pos -= 2;
      end
      t[n] = pos;
    end
  endfunction

  function automatic logic [11:0] colour(bit b, int x, int y);
    int idx, bx, by;
    if (!b) return 12'h000;
    case (m_mode)
      0: begin
        idx = x / 80;
        if (idx > 7) idx = 7;
        return bars[idx];
      end
      1: return (((x / 32) + (y / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
      2: return 12'(((x / 64) % 16) * 256 + ((y / 32) % 16) * 16 + m_cnt / 16);
      default: begin
        bx = bxs[frames % 1024];
        by = bys[frames % 1024];
        if (x >= bx && x < bx + 32 && y >= by && y < by + 32)
          return 12'hFFF;
        return 12'h004;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; frames = 0; nsamp = 0;
    pv1 = 1; pv2 = 1;
    q.delete();
  endtask

  task automatic drive(bit b, bit h, bit v, int x, int y, int md);
    exp_t e;
    iBlank_n = b; iHS = h; iVS = v;
    iX = 11'(x); iY = 11'(y); iMode = 2'(md);
    // frame start seen on the edge that samples this pixel
    if (nsamp >= 2 && !pv1 && pv2) begin
      m_mode = md;
      m_cnt = (m_cnt + 1) % 256;
      frames++;
    end
    e.rgb = colour(b, x, y);
    e.hs = h; e.vs = v; e.blank = b;
    e.cnt = 8'((nsamp >= 1 && !v && pv1) ? (m_cnt + 1) % 256 : m_cnt);
    q.push_back(e);
    pv2 = pv1; pv1 = v; nsamp++;
    @(negedge vga_clk);
  endtask

  task automatic rand_frame(int fm, bit near_box);
    int lo = 1 + $urandom_range(0, 1);
    int hi = 3 + $urandom_range(0, 5);
    int x, y, md;
    for (int i = 0; i < lo + hi; i++) begin
      md = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : fm;
      if (near_box || $urandom_range(0, 1) == 1) begin
        x = bxs[frames % 1024] - 2 + $urandom_range(0, 35);
        y = bys[frames % 1024] - 2 + $urandom_range(0, 35);
        if (x < 0) x = 0;
        if (y < 0) y = 0;
      end else begin
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 479);
      end
      drive($urandom_range(0, 4) != 0, $urandom_range(0, 1), i >= lo,
            x, y, md);
    end
  endtask

  task automatic release_reset();
    exp_t e;
    reset = 1'b0;
    model_reset();
    e = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, blank: 1'b0, cnt: 8'h00};
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge vga_clk);
      #1;
      if (running && !reset) begin
        if (q.size() == 0) begin
          check("underflow", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          check("pixel", 32'({oR, oG, oB, oHS, oVS, oBlank_n, oFrame_cnt}),
                32'(e));
        end
      end
    end
  end

  initial begin : stim
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
             12'hF0F, 12'hF00, 12'h00F, 12'h000};
    fill_axis(608, bxs);
    fill_axis(448, bys);
    model_reset();
    repeat (3) @(negedge vga_clk);
    check("reset_out", 32'({oR, oG, oB, oHS, oVS, oBlank_n, oFrame_cnt}),
          32'({12'h000, 1'b1, 1'b1, 1'b0, 8'h00}));
    running = 1;
    release_reset();
    // bars and clamp, mode 0 from reset
    drive(1, 1, 1, 0, 100, 0);
    drive(1, 0, 1, 80, 100, 0);
    drive(1, 1, 1, 400, 100, 0);
    drive(1, 0, 1, 639, 100, 0);
    drive(1, 1, 1, 700, 100, 0);
    // checker with and without blanking
    drive(1, 1, 0, 0, 0, 1);
    drive(0, 1, 1, 32, 0, 1);
    drive(0, 1, 1, 32, 0, 1);
    drive(1, 1, 1, 32, 0, 1);
    drive(1, 1, 1, 0, 32, 1);
    // mid-frame mode request only takes effect at the next frame
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 10, 10, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 80 * i, 60, 2);
    drive(1, 1, 0, 100, 200, 2);
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 64 * i, 32 * i, 2);
    // long random run covering box bounce and counter wrap
    for (int f = 0; f < 320; f++)
      rand_frame((f % 7 == 0) ? $urandom_range(0, 3) : 3, f % 3 == 0);
    check("frames_run", 32'(frames >= 306), 32'd1);
    // asynchronous reset in the middle of a frame
    drive(1, 1, 1, 50, 50, 3);
    #2 reset = 1'b1;
    #1;
    check("async_reset",
          32'({oR, oG, oB, oHS, oVS, oBlank_n, oFrame_cnt}),
          32'({12'h000, 1'b1, 1'b1, 1'b0, 8'h00}));
    q.delete();
    @(negedge vga_clk);
    @(negedge vga_clk);
    release_reset();
    drive(1, 1, 0, 0, 0, 3);
    drive(1, 1, 0, 0, 0, 3);
    drive(1, 1, 1, 0, 0, 3);
    drive(1, 1, 1, 31, 31, 3);
    drive(1, 1, 1, 32, 0, 3);
    for (int f = 0; f < 6; f++) rand_frame(3, 1);
    drive(1, 1, 1, 1, 1, 3);
    @(negedge vga_clk);
    check("drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
